// File: rtl/vec_packer_if.sv
// Handshake bundle between a scalar stream producer, the vector packer and the
// vector consumer. master = the environment side, slave = the packer.
interface vec_packer_if #(
    parameter int Elements = 8,
    parameter int Width    = 8
) ();
    localparam int CW = $clog2(Elements + 1);

    logic signed [Width-1:0]        in_data;
    logic                           in_valid;
    logic                           in_last;
    logic                           in_ready;
    logic [Elements-1:0][Width-1:0] out_vec;
    logic [CW-1:0]                  out_count;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_vec, out_count, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_vec, out_count, out_valid
    );
endinterface

// File: rtl/vec_packer.sv
// Packs a signed scalar stream into an Elements-lane vector; in_last closes a
// vector early and unfilled lanes stay zero so a downstream adder tree sums correctly.
//
//   state | meaning
//   FILL  | assembling lanes, in_ready=1
//   HOLD  | vector presented on out_vec, in_ready follows out_ready
module vec_packer #(
    parameter int Elements = 8,
    parameter int Width    = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    vec_packer_if.slave bus
);
    localparam int IW     = (Elements > 1) ? $clog2(Elements) : 1;
    localparam int CW     = $clog2(Elements + 1);
    localparam bit SINGLE = (Elements == 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [Elements-1:0][Width-1:0] vec_q, vec_d;
    logic [CW-1:0]                  count_q, count_d;
    logic                           valid_q, valid_d;
    logic                           in_ready;
    logic                           accept;
    logic                           xfer;

    assign in_ready = !rst_in && ((state_q == FILL) || bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign xfer     = valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        count_d = count_q;
        valid_d = valid_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < Elements; i++) begin
                        if (IW'(i) == idx_q) vec_d[i] = bus.in_data;
                    end
                    idx_d = idx_q + IW'(1);
                    if ((idx_q == IW'(Elements - 1)) || bus.in_last) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        count_d = CW'(idx_q) + CW'(1);
                        idx_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    vec_d   = '0;
                    idx_d   = '0;
                    count_d = '0;
                    valid_d = 1'b0;
                    state_d = FILL;
                    // An accept here can only coincide with a transfer; it opens the next vector.
                    if (accept) begin
                        vec_d[0] = bus.in_data;
                        if (SINGLE || bus.in_last) begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                            count_d = CW'(1);
                        end else begin
                            idx_d = IW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= FILL;
            idx_q   <= '0;
            vec_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_vec   = vec_q;
    assign bus.out_count = count_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_vec_packer.sv
// Scoreboard bench for vec_packer: an 8-lane and a 1-lane instance, directed
// streams with hand-computed vectors, counts and lane sums.
module tb_vec_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_packer_if #(.Elements(8), .Width(8)) b8 ();
    vec_packer_if #(.Elements(1), .Width(8)) b1 ();

    vec_packer #(.Elements(8), .Width(8)) dut8 (.clk_in(clk), .rst_in(rst), .bus(b8));
    vec_packer #(.Elements(1), .Width(8)) dut1 (.clk_in(clk), .rst_in(rst), .bus(b1));

    typedef struct {
        logic [63:0] vec;
        int          cnt;
        int          sum;
    } exp_t;

    exp_t        q8[$];
    logic [7:0]  q1[$];
    exp_t        e8;
    logic [7:0]  e1;
    int          s8;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push8(input logic [63:0] v, input int c, input int s);
        exp_t e;
        e.vec = v;
        e.cnt = c;
        e.sum = s;
        q8.push_back(e);
    endtask

    // Monitor: checks every transfer on the 8-lane instance against the queue.
    always @(negedge clk) begin
        if (!rst && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_vec8: actual=%0h required=none", b8.out_vec);
            end else begin
                e8 = q8.pop_front();
                s8 = 0;
                for (int i = 0; i < 8; i++) s8 += $signed(b8.out_vec[i]);
                chk("vec8", 64'(b8.out_vec), e8.vec);
                chk("count8", 64'(b8.out_count), 64'(e8.cnt));
                chk("sum8", 64'(s8), 64'(e8.sum));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_vec1: actual=%0h required=none", b1.out_vec);
            end else begin
                e1 = q1.pop_front();
                chk("vec1", 64'(b1.out_vec), 64'(e1));
                chk("count1", 64'(b1.out_count), 64'd1);
            end
        end
    end

    // Present one element and hold it until accepted; strict demands in_ready immediately.
    task automatic send8(input logic [7:0] d, input logic last, input bit strict);
        b8.in_data  = d;
        b8.in_valid = 1'b1;
        b8.in_last  = last;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (strict && n == 0) chk("b2b_in_ready", 64'(b8.in_ready), 64'd1);
            if (b8.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: actual=no_accept required=accept data=%0h", d);
    endtask

    task automatic idle8();
        b8.in_valid = 1'b0;
        b8.in_last  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        b8.in_data = '0; b8.in_valid = 1'b0; b8.in_last = 1'b0; b8.out_ready = 1'b1;
        b1.in_data = '0; b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("rst_in_ready8", 64'(b8.in_ready), 64'd0);
        chk("rst_in_ready1", 64'(b1.in_ready), 64'd0);
        chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
        chk("rst_out_count", 64'(b8.out_count), 64'd0);
        chk("rst_out_vec", 64'(b8.out_vec), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // full fill 1..8
        push8(64'h0807060504030201, 8, 36);
        for (int i = 1; i <= 8; i++) send8(8'(i), 1'b0, 1'b0);
        idle8();
        @(negedge clk);
        chk("latency_valid", 64'(b8.out_valid), 64'd1);
        cycles(1);
        @(negedge clk);
        chk("cleared_valid", 64'(b8.out_valid), 64'd0);
        chk("cleared_vec", 64'(b8.out_vec), 64'd0);
        cycles(1);

        // partial -1,-2,-3
        push8(64'h0000000000FDFEFF, 3, -6);
        send8(8'hFF, 1'b0, 1'b0);
        send8(8'hFE, 1'b0, 1'b0);
        send8(8'hFD, 1'b1, 1'b0);
        idle8();
        cycles(3);

        // back-pressure: 20..27 held for 5 cycles while new data waits
        b8.out_ready = 1'b0;
        push8(64'h1B1A191817161514, 8, 188);
        for (int i = 20; i <= 27; i++) send8(8'(i), 1'b0, 1'b0);
        b8.in_data  = 8'd99;
        b8.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(b8.in_ready), 64'd0);
            chk("bp_out_vec", 64'(b8.out_vec), 64'h1B1A191817161514);
            chk("bp_out_valid", 64'(b8.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        idle8();
        b8.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(b8.in_ready), 64'd1);
        cycles(2);

        // back-to-back 0..15, no input bubbles
        push8(64'h0706050403020100, 8, 28);
        push8(64'h0F0E0D0C0B0A0908, 8, 92);
        for (int i = 0; i < 16; i++) send8(8'(i), 1'b0, 1'b1);
        // next vector opened on the transfer cycle and closed at once by in_last
        push8(64'h3F3E3D3C3B3A3938, 8, 476);
        for (int i = 56; i <= 63; i++) send8(8'(i), 1'b0, 1'b1);
        push8(64'h0000000000000040, 1, 64);
        send8(8'h40, 1'b1, 1'b1);
        idle8();
        cycles(3);

        // in_last without in_valid is ignored; in_last on the 8th is a normal close
        push8(64'h0807060504030201, 8, 36);
        for (int i = 1; i <= 3; i++) send8(8'(i), 1'b0, 1'b0);
        b8.in_valid = 1'b0;
        b8.in_last  = 1'b1;
        cycles(2);
        for (int i = 4; i <= 7; i++) send8(8'(i), 1'b0, 1'b0);
        send8(8'd8, 1'b1, 1'b0);
        idle8();
        cycles(3);

        // reset mid-fill discards the partial vector
        for (int i = 30; i <= 33; i++) send8(8'(i), 1'b0, 1'b0);
        idle8();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        push8(64'h11100F0E0D0C0B0A, 8, 108);
        for (int i = 10; i <= 17; i++) send8(8'(i), 1'b0, 1'b0);
        idle8();
        cycles(3);

        // single-lane instance: every accept closes a vector
        q1.push_back(8'd5);
        q1.push_back(8'd6);
        q1.push_back(8'd7);
        b1.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b1.in_data = 8'(5 + i);
            @(negedge clk);
            chk("e1_in_ready", 64'(b1.in_ready), 64'd1);
            if (i > 0) chk("e1_valid_held", 64'(b1.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        b1.in_valid = 1'b0;
        @(negedge clk);
        chk("e1_last_valid", 64'(b1.out_valid), 64'd1);
        cycles(2);

        for (int n = 0; n < 20 && (q8.size() != 0 || q1.size() != 0); n++) cycles(1);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vec_packer.md
Name: vec_packer

Overview:
Stream-to-vector packer. It collects a stream of signed scalar elements, one per handshake, into a packed vector of Elements lanes. It is the producer end of the vector interface consumed by AdderTree: out_vec drives AdderTree.in directly. It provides valid/ready handshakes on both sides, supports early termination that produces a zero-padded partial vector, and sustains full throughput when output is not back-pressured.

Parameters:
Elements, 8, number of lanes in the output vector; must be >= 1.
Width, 8, bits per signed element.

Ports:
clk_in  input  1  system clock; all state updates on rising edge.
rst_in  input  1  synchronous, active-high reset.
in_data  input  Width  signed element to pack.
in_valid  input  1  in_data valid.
in_last  input  1  qualifies in_data as the final element of the current vector; closes it early.
in_ready  output  1  packer can accept in_data this cycle.
out_vec  output  [Elements-1:0][Width-1:0]  packed signed vector; lane 0 = first element accepted.
out_count  output  $clog2(Elements+1)  number of filled lanes in out_vec (1..Elements while out_valid).
out_valid  output  1  out_vec/out_count complete and stable.
out_ready  input  1  consumer accepts out_vec this cycle.

Behaviour:
- Reset (rst_in=1 at edge): state=FILL, idx=0, out_vec=all zeros, out_count=0, out_valid=0. in_ready=0 while rst_in=1.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- States: FILL (assembling), HOLD (vector presented).
- in_ready is combinational: 1 in FILL; equals out_ready in HOLD. This is the only comb path from out_ready to in_ready.
- FILL, on accept:
  - out_vec[idx] <= in_data; idx <= idx+1.
  - If idx==Elements-1 or in_last=1: go to HOLD, out_valid <= 1, out_count <= idx+1.
- FILL, no accept: hold all state.
- HOLD: out_vec and out_count are stable until transfer. in_valid/in_data changes do not affect them.
- HOLD, transfer without accept:
  - out_valid <= 0, idx <= 0, out_vec <= 0, out_count <= 0.
  - Go to FILL.
- HOLD, transfer with simultaneous accept:
  - New vector begins. out_vec <= {0..., in_data in lane 0}, idx <= 1.
  - If Elements==1 or in_last=1: stay in HOLD, out_valid stays 1, out_count <= 1.
  - Else: go to FILL, out_valid <= 0, out_count <= 0.
- Unfilled lanes of a partial vector are exactly 0, so an AdderTree sum equals the sum of the accepted elements.
- Latency: out_valid asserts on the cycle after the closing element is accepted.
- Throughput: one element per cycle sustained with out_ready=1. Zero bubbles on the input side across vector boundaries.
- in_last on the Elements-th element: same as a normal full close, out_count=Elements.
- in_last while in_valid=0: ignored.
- Values are stored verbatim. No arithmetic and no sign manipulation.
- Reset mid-fill or mid-HOLD: the partial or held vector is discarded. The next accepted element lands in lane 0.
- Elements==1: every accept closes a vector. idx never exceeds 0.

Test Plan:
- Full fill: Elements=8, Width=8, out_ready=1, stream 1..8 one per cycle -> one cycle later out_valid=1, lanes 0..7 = 1..8, out_count=8, AdderTree out=36.
- Partial: stream -1,-2,-3 with in_last on -3 -> out_count=3, lanes 0..2 = -1,-2,-3, lanes 3..7 = 0, AdderTree out=-6.
- Back-pressure: fill 8 elements with out_ready=0 for 5 cycles -> in_ready=0 and out_vec unchanged all 5 cycles. Raise out_ready -> transfer occurs, in_ready=1 the same cycle.
- Back-to-back: 16 consecutive elements 0..15 with in_valid=1, out_ready=1 -> in_ready never drops. Vectors {0..7} then {8..15} are transferred. First element of each new vector is accepted on the prior transfer cycle.
- Reset mid-fill: accept 4 elements, pulse rst_in one cycle, then stream 10..17 -> out_vec = 10..17, out_count=8. No residue from the first 4 elements.
- Elements=1 instance: stream 5,6,7 with out_ready=1 -> out_valid stays high and out_vec updates 5,6,7 on consecutive cycles, out_count=1 throughout.
